// File: rtl/race_ctrl.sv
// Race sequencer: start-light countdown, lap counting with checkpoint
// arming, seconds timer, finish-screen hold and return to idle.
module race_ctrl #(
  parameter int TICK_CYCLES = 65000000,
  parameter int COUNT_FROM  = 3,
  parameter int LAPS        = 3,
  parameter int FINISH_HOLD = 5
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       game_visible,
  input  logic       abort,
  input  logic [3:0] controls_in,
  input  logic       line_cross,
  input  logic       checkpoint,
  output logic [3:0] controls_out,
  output logic [3:0] countdown,
  output logic       go_visible,
  output logic [3:0] lap,
  output logic [9:0] race_time,
  output logic       finish_visible,
  output logic       race_done,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    COUNTDOWN = 2'b01,
    RACING    = 2'b10,
    FINISHED  = 2'b11
  } state_t;

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int HW = $clog2(FINISH_HOLD + 2);
  localparam logic [CW-1:0] TICK_MAX = CW'(TICK_CYCLES - 1);
  localparam logic [3:0] CNT0 = 4'(COUNT_FROM);
  localparam logic [3:0] LAP_N = 4'(LAPS);
  localparam logic [HW-1:0] HOLD_N = HW'(FINISH_HOLD);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hold;
  logic          gv_prev;
  logic          armed;
  logic          rise;
  logic          kill;
  logic          tick;
  logic          lap_end;
  logic          hold_end;
  logic          cd_end;
  logic          moving;

  assign rise = game_visible & ~gv_prev;
  assign kill = abort | (~game_visible & (state != IDLE));
  assign tick = (state != IDLE) && (cnt == TICK_MAX);
  assign lap_end = (state == RACING) && line_cross && armed &&
                   ((lap + 4'd1) == LAP_N);
  assign hold_end = (hold + HW'(1)) >= HOLD_N;
  assign cd_end = (state == COUNTDOWN) && tick && (countdown == 4'd1);
  assign moving = kill | cd_end | lap_end |
                  ((state == FINISHED) && tick && hold_end);
  assign state_dbg = state;

  // One-second tick divider, restarted whenever the state changes
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if ((state == IDLE) || moving || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Race state machine with all outputs registered
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      gv_prev        <= 1'b0;
      armed          <= 1'b0;
      hold           <= '0;
      controls_out   <= '0;
      countdown      <= '0;
      go_visible     <= 1'b0;
      lap            <= '0;
      race_time      <= '0;
      finish_visible <= 1'b0;
      race_done      <= 1'b0;
    end else begin
      gv_prev   <= game_visible;
      race_done <= 1'b0;
      if (kill) begin
        state          <= IDLE;
        armed          <= 1'b0;
        hold           <= '0;
        controls_out   <= '0;
        countdown      <= '0;
        go_visible     <= 1'b0;
        lap            <= '0;
        race_time      <= '0;
        finish_visible <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            controls_out   <= '0;
            countdown      <= '0;
            go_visible     <= 1'b0;
            finish_visible <= 1'b0;
            hold           <= '0;
            if (rise) begin
              state     <= COUNTDOWN;
              countdown <= CNT0;
              lap       <= '0;
              race_time <= '0;
              armed     <= 1'b0;
            end
          end
          COUNTDOWN: begin
            controls_out <= '0;
            if (tick) begin
              if (countdown == 4'd1) begin
                state      <= RACING;
                countdown  <= '0;
                go_visible <= 1'b1;
              end else begin
                countdown <= countdown - 4'd1;
              end
            end
          end
          RACING: begin
            if (tick) begin
              go_visible <= 1'b0;
              if (race_time != 10'h3FF) begin
                race_time <= race_time + 10'd1;
              end
            end
            if (line_cross && armed) begin
              lap   <= lap + 4'd1;
              armed <= checkpoint;
            end else if (checkpoint) begin
              armed <= 1'b1;
            end
            if (lap_end) begin
              state          <= FINISHED;
              race_done      <= 1'b1;
              finish_visible <= 1'b1;
              go_visible     <= 1'b0;
              controls_out   <= '0;
              hold           <= '0;
            end else begin
              controls_out <= controls_in;
            end
          end
          FINISHED: begin
            controls_out <= '0;
            if (tick) begin
              if (hold_end) begin
                state          <= IDLE;
                finish_visible <= 1'b0;
              end else begin
                hold <= hold + HW'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_race_ctrl.sv
// Bench for race_ctrl: directed scenarios plus randomized traffic
// compared against an elapsed-time reference model.
module tb_race_ctrl;

  localparam int TICK = 4;
  localparam int CFROM = 3;
  localparam int NLAPS = 2;
  localparam int FHOLD = 2;

  logic       pclk;
  logic       rst_n;
  logic       game_visible;
  logic       abort;
  logic [3:0] controls_in;
  logic       line_cross;
  logic       checkpoint;
  logic [3:0] controls_out;
  logic [3:0] countdown;
  logic       go_visible;
  logic [3:0] lap;
  logic [9:0] race_time;
  logic       finish_visible;
  logic       race_done;
  logic [1:0] state_dbg;
  logic [26:0] act;

  int total = 0;
  int bad = 0;

  int m_st, m_cyc, m_lap, m_rt, m_ctl;
  bit m_arm, m_gvp;

  race_ctrl #(
    .TICK_CYCLES(TICK),
    .COUNT_FROM(CFROM),
    .LAPS(NLAPS),
    .FINISH_HOLD(FHOLD)
  ) dut (
    .pclk(pclk),
    .rst_n(rst_n),
    .game_visible(game_visible),
    .abort(abort),
    .controls_in(controls_in),
    .line_cross(line_cross),
    .checkpoint(checkpoint),
    .controls_out(controls_out),
    .countdown(countdown),
    .go_visible(go_visible),
    .lap(lap),
    .race_time(race_time),
    .finish_visible(finish_visible),
    .race_done(race_done),
    .state_dbg(state_dbg)
  );

  assign act = {controls_out, countdown, go_visible, lap, race_time,
                finish_visible, race_done, state_dbg};

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic model_reset();
    m_st = 0; m_cyc = 0; m_lap = 0; m_rt = 0; m_ctl = 0;
    m_arm = 0; m_gvp = 0;
  endtask

  // phases: 0 idle, 1 countdown, 2 racing, 3 finished; m_cyc = cycles in phase
  task automatic model_step();
    bit rise, kill;
    rise = game_visible && !m_gvp;
    m_gvp = game_visible;
    kill = abort || (!game_visible && m_st != 0);
    if (kill) begin
      m_st = 0; m_cyc = 0; m_lap = 0; m_rt = 0; m_arm = 0; m_ctl = 0;
      return;
    end
    case (m_st)
      0: begin
        m_ctl = 0;
        if (rise) begin
          m_st = 1; m_cyc = 0; m_lap = 0; m_rt = 0; m_arm = 0;
        end
      end
      1: begin
        m_ctl = 0;
        if (m_cyc + 1 == CFROM * TICK) begin
          m_st = 2; m_cyc = 0;
        end else m_cyc++;
      end
      2: begin
        if (line_cross && m_arm) begin
          m_lap++;
          m_arm = checkpoint;
        end else if (checkpoint) m_arm = 1;
        if (m_lap == NLAPS) begin
          m_rt = ((m_cyc + 1) / TICK > 1023) ? 1023 : (m_cyc + 1) / TICK;
          m_st = 3; m_cyc = 0; m_ctl = 0;
        end else begin
          m_ctl = int'(controls_in);
          m_cyc++;
        end
      end
      default: begin
        m_ctl = 0;
        if (m_cyc + 1 == FHOLD * TICK) begin
          m_st = 0; m_cyc = 0;
        end else m_cyc++;
      end
    endcase
  endtask

  function automatic logic [26:0] exp_out();
    logic [3:0] cd;
    logic [9:0] rt;
    logic go, fin, done;
    cd = (m_st == 1) ? 4'(CFROM - m_cyc / TICK) : 4'd0;
    go = (m_st == 2) && (m_cyc < TICK);
    if (m_st == 2) rt = 10'((m_cyc / TICK > 1023) ? 1023 : m_cyc / TICK);
    else rt = 10'(m_rt);
    fin = (m_st == 3);
    done = (m_st == 3) && (m_cyc == 0);
    return {4'(m_ctl), cd, go, 4'(m_lap), rt, fin, done, 2'(m_st)};
  endfunction

  task automatic step();
    @(posedge pclk);
    model_step();
    @(negedge pclk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 0; game_visible = 0; abort = 0;
    controls_in = 4'h0; line_cross = 0; checkpoint = 0;
    model_reset();
    @(posedge pclk);
    @(negedge pclk);
    total++;
    if (act !== 27'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", act);
    end
    rst_n = 1;
    step();
    total++;
    if (state_dbg !== 2'b00) begin
      bad++; $display("FAIL reset_state got=%0d want=0", state_dbg);
    end
  endtask

  task automatic test_countdown();
    controls_in = 4'hF;
    game_visible = 1;
    step();
    for (int i = 0; i < 12; i++) begin
      total++;
      if (state_dbg !== 2'b01 || countdown !== 4'(3 - i / 4) ||
          controls_out !== 4'h0) begin
        bad++;
        $display("FAIL countdown_%0d got st=%0d cd=%0d ctl=%h want st=1 cd=%0d ctl=0",
                 i, state_dbg, countdown, controls_out, 3 - i / 4);
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (state_dbg !== 2'b10 || countdown !== 4'd0 || go_visible !== 1'b1) begin
        bad++;
        $display("FAIL go_banner_%0d got st=%0d cd=%0d go=%b want st=2 cd=0 go=1",
                 i, state_dbg, countdown, go_visible);
      end
      step();
    end
    total++;
    if (go_visible !== 1'b0) begin
      bad++; $display("FAIL go_clear got=%b want=0", go_visible);
    end
  endtask

  task automatic test_controls();
    controls_in = 4'b1001;
    step();
    total++;
    if (controls_out !== 4'b1001) begin
      bad++; $display("FAIL controls_pass got=%b want=1001", controls_out);
    end
    steps(7);
    total++;
    if (race_time !== 10'd3) begin
      bad++; $display("FAIL race_time_12 got=%0d want=3", race_time);
    end
  endtask

  task automatic test_laps();
    line_cross = 1; step(); line_cross = 0;
    total++;
    if (lap !== 4'd0) begin
      bad++; $display("FAIL lap_unarmed got=%0d want=0", lap);
    end
    checkpoint = 1; step(); checkpoint = 0;
    line_cross = 1; step(); line_cross = 0;
    total++;
    if (lap !== 4'd1) begin
      bad++; $display("FAIL lap_armed got=%0d want=1", lap);
    end
    line_cross = 1; step(); line_cross = 0;
    total++;
    if (lap !== 4'd1) begin
      bad++; $display("FAIL lap_rearm got=%0d want=1", lap);
    end
    game_visible = 0; step();
    total++;
    if (state_dbg !== 2'b00 || lap !== 4'd0) begin
      bad++;
      $display("FAIL gv_drop got st=%0d lap=%0d want st=0 lap=0", state_dbg, lap);
    end
  endtask

  task automatic test_finish();
    controls_in = 4'b0110;
    game_visible = 1; step();
    steps(12);
    checkpoint = 1; step(); checkpoint = 0;
    total++;
    if (lap !== 4'd0) begin
      bad++; $display("FAIL lap_cp_only got=%0d want=0", lap);
    end
    checkpoint = 1; line_cross = 1; step();
    checkpoint = 0; line_cross = 0;
    total++;
    if (lap !== 4'd1) begin
      bad++; $display("FAIL lap_simul got=%0d want=1", lap);
    end
    line_cross = 1; step(); line_cross = 0;
    total++;
    if (lap !== 4'd2 || race_done !== 1'b1 || finish_visible !== 1'b1 ||
        controls_out !== 4'h0 || state_dbg !== 2'b11) begin
      bad++;
      $display("FAIL finish_enter got lap=%0d done=%b fin=%b ctl=%h st=%0d want 2 1 1 0 3",
               lap, race_done, finish_visible, controls_out, state_dbg);
    end
    step();
    total++;
    if (race_done !== 1'b0 || state_dbg !== 2'b11) begin
      bad++;
      $display("FAIL done_pulse got done=%b st=%0d want done=0 st=3", race_done, state_dbg);
    end
    steps(6);
    total++;
    if (state_dbg !== 2'b11) begin
      bad++; $display("FAIL finish_hold got st=%0d want=3", state_dbg);
    end
    step();
    total++;
    if (state_dbg !== 2'b00 || finish_visible !== 1'b0 || lap !== 4'd2) begin
      bad++;
      $display("FAIL finish_exit got st=%0d fin=%b lap=%0d want st=0 fin=0 lap=2",
               state_dbg, finish_visible, lap);
    end
  endtask

  task automatic test_abort();
    steps(3);
    total++;
    if (state_dbg !== 2'b00) begin
      bad++; $display("FAIL no_retrigger got st=%0d want=0", state_dbg);
    end
    game_visible = 0; step();
    game_visible = 1; step();
    steps(4);
    total++;
    if (state_dbg !== 2'b01 || countdown !== 4'd2) begin
      bad++;
      $display("FAIL pre_abort got st=%0d cd=%0d want st=1 cd=2", state_dbg, countdown);
    end
    abort = 1; step(); abort = 0;
    total++;
    if (state_dbg !== 2'b00 || countdown !== 4'd0) begin
      bad++;
      $display("FAIL abort got st=%0d cd=%0d want st=0 cd=0", state_dbg, countdown);
    end
    steps(3);
    total++;
    if (state_dbg !== 2'b00) begin
      bad++; $display("FAIL abort_hold got st=%0d want=0", state_dbg);
    end
    game_visible = 0; step();
    game_visible = 1; step();
    total++;
    if (state_dbg !== 2'b01 || countdown !== 4'd3) begin
      bad++;
      $display("FAIL restart got st=%0d cd=%0d want st=1 cd=3", state_dbg, countdown);
    end
  endtask

  task automatic test_async_reset();
    steps(12);
    controls_in = 4'($urandom);
    steps(3);
    total++;
    if (state_dbg !== 2'b10) begin
      bad++; $display("FAIL pre_reset got st=%0d want=2", state_dbg);
    end
    @(posedge pclk);
    model_step();
    #3;
    rst_n = 0;
    #1;
    total++;
    if (act !== 27'd0) begin
      bad++; $display("FAIL async_reset got=%h want=0", act);
    end
    model_reset();
    game_visible = 0;
    @(negedge pclk);
    rst_n = 1;
    #1;
    total++;
    if (state_dbg !== 2'b00) begin
      bad++; $display("FAIL post_reset got st=%0d want=0", state_dbg);
    end
  endtask

  task automatic test_random();
    logic [26:0] e;
    @(negedge pclk);
    for (int i = 0; i < 3000; i++) begin
      game_visible = ($urandom_range(0, 299) != 0);
      abort = ($urandom_range(0, 499) == 0);
      line_cross = ($urandom_range(0, 7) == 0);
      checkpoint = ($urandom_range(0, 5) == 0);
      controls_in = 4'($urandom);
      step();
      e = exp_out();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL random_%0d got=%h want=%h", i, act, e);
      end
    end
    abort = 0; line_cross = 0; checkpoint = 0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_controls();
    test_laps();
    test_finish();
    test_abort();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
